// File: rtl/imem_loader_if.sv
// Byte-stream link from the program source into the instruction-memory loader.
//   in_valid  source has a byte on in_data
//   in_data   byte, sent least-significant byte of each word first
//   in_last   final byte of the program; only meaningful with in_valid
//   in_ready  loader accepts a byte this cycle
// master = byte source, slave = loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Program loader for the single-cycle CPU. Packs a little-endian byte stream
// into 32-bit words, writes them to instruction memory, then releases the CPU
// via cpu_start. The CPU is held off (cpu_start=0) while a program is loading.
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   src          byte stream (slave side of imem_loader_if)
//   reload       in DONE: drop the loaded program and start a new load
//   mem_we       one-cycle write strobe per stored word
//   mem_addr     byte address of the stored word (word_index*4)
//   mem_wdata    stored word; unfilled tail lanes are zero
//   cpu_start    1 = CPU runs
//   word_count   words stored in this load, saturates at MAX_WORDS
//   overflow     sticky: program longer than MAX_WORDS, excess dropped
//   partial      sticky: program ended mid-word, tail zero-padded

// One byte lane of the word assembly register. q_nxt is the lane value
// including a byte being accepted this cycle, so a completed word can be
// stored on the same edge that accepts its final byte.
module imem_lane #(
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] q_nxt
);
    logic [VEC_W-1:0] q;

    assign q_nxt = wr_en ? din : q;

    // clr wins over wr_en: the byte that completes a word goes out through
    // q_nxt and must not linger into the next word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       q <= '0;
        else if (clr)   q <= '0;
        else if (wr_en) q <= din;
    end
endmodule

module imem_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 11      // 2**CNT_W must exceed MAX_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    imem_loader_if.slave     src,
    input  logic             reload,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_start,
    output logic [CNT_W-1:0] word_count,
    output logic             overflow,
    output logic             partial
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [1:0]       LANE_TOP = 2'(NUM_LANES - 1);

    logic [1:0]                          state, state_nxt;
    logic [1:0]                          lane;
    logic [CNT_W-1:0]                    word_idx;
    logic                                accept, word_done, mem_full, lane_clr;
    logic [NUM_LANES-1:0]                lane_wr;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_nxt;

    assign src.in_ready = (state == S_LOAD);
    assign accept       = src.in_valid && src.in_ready;
    assign word_done    = accept && ((lane == LANE_TOP) || src.in_last);
    assign mem_full     = (word_idx == MAX_CNT);
    assign lane_clr     = word_done || (state == S_IDLE);

    // Word index and word_count advance together and both stop at MAX_WORDS.
    assign word_count = word_idx;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_wr[i] = accept && (lane == 2'(i));

        imem_lane #(.VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (lane_clr),
            .wr_en (lane_wr[i]),
            .din   (src.in_data),
            .q_nxt (lane_nxt[i])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_LOAD;
            S_LOAD:  if (accept && src.in_last) state_nxt = S_DONE;
            S_DONE:  if (reload) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lane      <= '0;
            word_idx  <= '0;
            overflow  <= 1'b0;
            partial   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            // Registered from the next state so the CPU starts on the first
            // DONE cycle and stops on the first cycle after reload.
            cpu_start <= (state_nxt == S_DONE);
            mem_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    lane     <= '0;
                    word_idx <= '0;
                    overflow <= 1'b0;
                    partial  <= 1'b0;
                end
                S_LOAD: begin
                    if (accept) begin
                        lane <= word_done ? 2'd0 : lane + 2'd1;
                        if (src.in_last && (lane != LANE_TOP)) partial <= 1'b1;
                        if (word_done) begin
                            if (mem_full) begin
                                // Memory is full: keep draining the stream
                                // to in_last but store nothing more.
                                overflow <= 1'b1;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= 32'(word_idx) << 2;
                                mem_wdata <= lane_nxt;
                                word_idx  <= word_idx + CNT_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
